// File: rtl/wifi_tx_pkg.sv
// rtl/wifi_tx_pkg.sv - shared states, rate codes, field widths and SIGNAL builder
//
// Purpose: common definitions imported by the frame sequencer and its rate LUT.
// Ports: none (package).

package wifi_tx_pkg;

  // Sequencer states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SIGNAL  = 3'd1;
  localparam logic [2:0] ST_SERVICE = 3'd2;
  localparam logic [2:0] ST_DATA    = 3'd3;
  localparam logic [2:0] ST_TAIL    = 3'd4;
  localparam logic [2:0] ST_PAD     = 3'd5;
  localparam logic [2:0] ST_GAP     = 3'd6;

  // Field widths in bits
  localparam int SIGNAL_BITS  = 24;
  localparam int SERVICE_BITS = 16;
  localparam int TAIL_BITS    = 6;

  // Legal RATE codes {R1,R2,R3,R4}
  localparam logic [3:0] RATE_6M  = 4'hD;
  localparam logic [3:0] RATE_9M  = 4'hF;
  localparam logic [3:0] RATE_12M = 4'h5;
  localparam logic [3:0] RATE_18M = 4'h7;
  localparam logic [3:0] RATE_24M = 4'h9;
  localparam logic [3:0] RATE_36M = 4'hB;
  localparam logic [3:0] RATE_48M = 4'h1;
  localparam logic [3:0] RATE_54M = 4'h3;

  typedef struct packed {
    logic       legal;
    logic [7:0] ndbps;
  } rate_info_t;

  // SIGNAL field arranged so bit 0 is transmitted first: R1..R4, reserved,
  // LENGTH LSB first, even parity over those 17 bits, six tail zeros.
  function automatic logic [23:0] signal_field(input logic [3:0]  rate,
                                               input logic [11:0] length);
    logic [23:0] f;
    f        = '0;
    f[0]     = rate[3];
    f[1]     = rate[2];
    f[2]     = rate[1];
    f[3]     = rate[0];
    f[16:5]  = length;
    f[17]    = ^{rate, length};
    return f;
  endfunction

endpackage

// File: rtl/wifi_tx_rate_lut.sv
// rtl/wifi_tx_rate_lut.sv - combinational RATE code to {legal, N_DBPS} lookup
//
// Purpose: decodes the 4-bit RATE field into data bits per OFDM symbol.
// Ports:
//   i_rate  in  4  RATE code {R1,R2,R3,R4}
//   o_info  out 9  {legal, N_DBPS[7:0]}; all zero for an illegal code

module wifi_tx_rate_lut
  import wifi_tx_pkg::*;
(
  input  logic [3:0] i_rate,
  output rate_info_t o_info
);

  always_comb begin
    o_info = '0;
    case (i_rate)
      RATE_6M:  o_info = '{legal: 1'b1, ndbps: 8'd24};
      RATE_9M:  o_info = '{legal: 1'b1, ndbps: 8'd36};
      RATE_12M: o_info = '{legal: 1'b1, ndbps: 8'd48};
      RATE_18M: o_info = '{legal: 1'b1, ndbps: 8'd72};
      RATE_24M: o_info = '{legal: 1'b1, ndbps: 8'd96};
      RATE_36M: o_info = '{legal: 1'b1, ndbps: 8'd144};
      RATE_48M: o_info = '{legal: 1'b1, ndbps: 8'd192};
      RATE_54M: o_info = '{legal: 1'b1, ndbps: 8'd216};
      default:  o_info = '0;
    endcase
  end

endmodule

// File: rtl/wifi_tx_frame_sequencer.sv
// rtl/wifi_tx_frame_sequencer.sv - serialises one 802.11a PPDU into the TX scrambler
//
// Purpose: emits SIGNAL, SERVICE, PSDU, TAIL and PAD bits one per clock with
// continuous scrambler valid, then a fixed low gap so the scrambler re-seeds.
// Ports:
//   clk           in   1          clock
//   reset         in   1          asynchronous active-low reset
//   i_start       in   1          frame request, sampled only in IDLE
//   i_rate        in   4          RATE code, R1 = i_rate[3]
//   i_length      in   12         PSDU length in bytes (1..4095)
//   i_byte_data   in   8          PSDU byte, LSB sent first
//   i_byte_valid  in   1          i_byte_data valid
//   o_byte_ready  out  1          byte accepted when i_byte_valid is also high
//   o_sc_valid    out  1          scrambler valid_in
//   o_sc_data     out  1          scrambler data_in
//   o_busy        out  1          frame or gap in progress
//   o_done        out  1          pulse on first gap cycle of a complete frame
//   o_error       out  1          pulse on rejected start or byte underrun
//   o_n_sym       out  SYM_CNT_W  DATA-field symbols in the last complete frame

module wifi_tx_frame_sequencer
  import wifi_tx_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int SYM_CNT_W  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [3:0]           i_rate,
  input  logic [11:0]          i_length,
  input  logic [7:0]           i_byte_data,
  input  logic                 i_byte_valid,
  output logic                 o_byte_ready,
  output logic                 o_sc_valid,
  output logic                 o_sc_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [SYM_CNT_W-1:0] o_n_sym
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [2:0]           r_state;
  logic [7:0]           r_ndbps;
  logic [23:0]          r_sig;
  logic [4:0]           r_cnt;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;
  logic [7:0]           r_hold;
  logic                 r_hold_full;
  logic [11:0]          r_fetch_left;
  logic [11:0]          r_tx_left;
  logic [7:0]           r_sym_bit;
  logic [SYM_CNT_W-1:0] r_sym_cnt;
  logic [SYM_CNT_W-1:0] r_n_sym;
  logic                 r_done;
  logic                 r_error;

  rate_info_t w_start_info;
  logic       w_active;
  logic       w_sym_phase;
  logic       w_sym_wrap;
  logic       w_byte_ready;
  logic       w_take;
  logic       w_last_byte;

  wifi_tx_rate_lut u_rate_lut (
    .i_rate (i_rate),
    .o_info (w_start_info)
  );

  assign w_active     = (r_state == ST_SIGNAL) || (r_state == ST_SERVICE) ||
                        (r_state == ST_DATA)   || (r_state == ST_TAIL)    ||
                        (r_state == ST_PAD);
  // The symbol bit counter only covers the DATA field (SERVICE onwards).
  assign w_sym_phase  = w_active && (r_state != ST_SIGNAL);
  assign w_sym_wrap   = w_sym_phase && (r_sym_bit == (r_ndbps - 8'd1));
  // Fetching starts in SERVICE so the first byte is held before DATA begins.
  assign w_byte_ready = !r_hold_full && (r_fetch_left != 12'd0) &&
                        ((r_state == ST_SERVICE) || (r_state == ST_DATA));
  assign w_take       = w_byte_ready && i_byte_valid;
  assign w_last_byte  = (r_tx_left == 12'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_ndbps      <= '0;
      r_sig        <= '0;
      r_cnt        <= '0;
      r_gap_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_fetch_left <= '0;
      r_tx_left    <= '0;
      r_sym_bit    <= '0;
      r_sym_cnt    <= '0;
      r_n_sym      <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;

      if (w_take) begin
        r_hold       <= i_byte_data;
        r_hold_full  <= 1'b1;
        r_fetch_left <= r_fetch_left - 12'd1;
      end

      if (w_sym_phase) begin
        if (w_sym_wrap) begin
          r_sym_bit <= '0;
          r_sym_cnt <= r_sym_cnt + SYM_CNT_W'(1);
        end else begin
          r_sym_bit <= r_sym_bit + 8'd1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (w_start_info.legal && (i_length != 12'd0)) begin
              r_state      <= ST_SIGNAL;
              r_ndbps      <= w_start_info.ndbps;
              r_sig        <= signal_field(i_rate, i_length);
              r_cnt        <= '0;
              r_fetch_left <= i_length;
              r_tx_left    <= i_length;
              r_hold_full  <= 1'b0;
              r_sym_bit    <= '0;
              r_sym_cnt    <= '0;
            end else begin
              r_error <= 1'b1;
            end
          end
        end

        ST_SIGNAL: begin
          r_sig <= {1'b0, r_sig[23:1]};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'(SIGNAL_BITS - 1)) begin
            r_state <= ST_SERVICE;
            r_cnt   <= '0;
          end
        end

        ST_SERVICE: begin
          r_cnt <= r_cnt + 5'd1;
          // Last SERVICE bit is the first byte boundary.
          if (r_cnt == 5'(SERVICE_BITS - 1)) begin
            if (r_hold_full) begin
              r_state     <= ST_DATA;
              r_shift     <= r_hold;
              r_hold_full <= 1'b0;
              r_bit_idx   <= '0;
            end else begin
              r_state      <= ST_GAP;
              r_gap_cnt    <= '0;
              r_error      <= 1'b1;
              r_hold_full  <= 1'b0;
              r_fetch_left <= '0;
            end
          end
        end

        ST_DATA: begin
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_idx <= r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            if (w_last_byte) begin
              r_state <= ST_TAIL;
              r_cnt   <= '0;
            end else if (r_hold_full) begin
              r_shift     <= r_hold;
              r_hold_full <= 1'b0;
              r_tx_left   <= r_tx_left - 12'd1;
            end else begin
              // Underrun: drop valid now; unfetched bytes are abandoned.
              r_state      <= ST_GAP;
              r_gap_cnt    <= '0;
              r_error      <= 1'b1;
              r_hold_full  <= 1'b0;
              r_fetch_left <= '0;
            end
          end
        end

        ST_TAIL: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'(TAIL_BITS - 1)) begin
            if (w_sym_wrap) begin
              r_state   <= ST_GAP;
              r_gap_cnt <= '0;
              r_done    <= 1'b1;
              r_n_sym   <= r_sym_cnt + SYM_CNT_W'(1);
            end else begin
              r_state <= ST_PAD;
            end
          end
        end

        ST_PAD: begin
          if (w_sym_wrap) begin
            r_state   <= ST_GAP;
            r_gap_cnt <= '0;
            r_done    <= 1'b1;
            r_n_sym   <= r_sym_cnt + SYM_CNT_W'(1);
          end
        end

        ST_GAP: begin
          r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_byte_ready = w_byte_ready;
  assign o_sc_valid   = w_active;
  assign o_sc_data    = (r_state == ST_SIGNAL) ? r_sig[0] :
                        (r_state == ST_DATA)   ? r_shift[0] : 1'b0;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_n_sym      = r_n_sym;

endmodule

// File: tb/tb_wifi_tx_frame_sequencer.sv
// tb/tb_wifi_tx_frame_sequencer.sv - self-checking bench with a bit-stream reference model

module tb_wifi_tx_frame_sequencer;

  localparam int GAP_CYCLES = 2;
  localparam int SYM_CNT_W  = 10;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 i_start = 1'b0;
  logic [3:0]           i_rate = '0;
  logic [11:0]          i_length = '0;
  logic [7:0]           i_byte_data = '0;
  logic                 i_byte_valid = 1'b0;
  logic                 o_byte_ready;
  logic                 o_sc_valid;
  logic                 o_sc_data;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_error;
  logic [SYM_CNT_W-1:0] o_n_sym;

  always #5 clk = ~clk;

  wifi_tx_frame_sequencer #(.GAP_CYCLES(GAP_CYCLES), .SYM_CNT_W(SYM_CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_rate       (i_rate),
    .i_length     (i_length),
    .i_byte_data  (i_byte_data),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .o_sc_valid   (o_sc_valid),
    .o_sc_data    (o_sc_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_n_sym      (o_n_sym)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ndbps_of(input logic [3:0] r);
    case (r)
      4'hD: return 24;
      4'hF: return 36;
      4'h5: return 48;
      4'h7: return 72;
      4'h9: return 96;
      4'hB: return 144;
      4'h1: return 192;
      4'h3: return 216;
      default: return 0;
    endcase
  endfunction

  logic [7:0] src [0:4095];

  // Byte source: presents src[n] for the n-th byte of the current frame.
  int feed_idx    = 0;
  bit feed_hs     = 1'b0;
  int stall_after = -1;
  int stall_len   = 0;
  int stall_cnt   = 0;
  bit rnd_valid   = 1'b0;

  always begin
    @(negedge clk);
    feed_hs = reset && i_byte_valid && o_byte_ready;
    if (i_start && !o_busy) begin
      feed_idx  = 0;
      stall_cnt = 0;
      feed_hs   = 1'b0;
    end
    @(posedge clk);
    #1;
    if (feed_hs) feed_idx++;
    i_byte_data = src[feed_idx % 4096];
    if (feed_idx == stall_after && stall_cnt < stall_len) begin
      i_byte_valid = 1'b0;
      stall_cnt++;
    end else if (rnd_valid) begin
      i_byte_valid = ($urandom_range(0, 1) == 1);
    end else begin
      i_byte_valid = 1'b1;
    end
  end

  // Reference model: the whole frame is a precomputed bit queue; the only
  // dynamic parts are the one-byte holding slot and the gap.
  int m_mode = 0;  // 0 idle, 1 frame, 2 gap
  int m_pos = 0;
  int m_len = 0;
  int m_nd = 0;
  int m_fetched = 0;
  int m_gap_left = 0;
  int m_nsym = 0;
  bit m_hold = 1'b0;
  bit m_done = 1'b0;
  bit m_err = 1'b0;
  bit m_bits[$];

  always @(negedge clk) begin : model
    bit e_ready;
    bit under;
    bit par;
    int nd;
    if (!reset) begin
      m_mode = 0; m_hold = 1'b0; m_done = 1'b0; m_err = 1'b0; m_nsym = 0;
      chk("rst_sc_valid", o_sc_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_byte_ready", o_byte_ready, 0);
    end else begin
      e_ready = (m_mode == 1) && !m_hold && (m_fetched < m_len) &&
                (m_pos >= 24) && (m_pos < 40 + 8 * m_len);
      chk("sc_valid", o_sc_valid, (m_mode == 1));
      chk("sc_data", o_sc_data, (m_mode == 1) ? m_bits[m_pos] : 0);
      chk("byte_ready", o_byte_ready, e_ready);
      chk("busy", o_busy, (m_mode != 0));
      chk("done", o_done, m_done);
      chk("error", o_error, m_err);
      chk("n_sym", o_n_sym, m_nsym);
      m_done = 1'b0;
      m_err  = 1'b0;
      case (m_mode)
        0: begin
          if (i_start) begin
            nd = ndbps_of(i_rate);
            if (nd == 0 || i_length == 12'd0) begin
              m_err = 1'b1;
            end else begin
              m_bits.delete();
              for (int i = 3; i >= 0; i--) m_bits.push_back(i_rate[i]);
              m_bits.push_back(1'b0);
              for (int i = 0; i < 12; i++) m_bits.push_back(i_length[i]);
              par = (($countones({i_rate, i_length}) % 2) == 1);
              m_bits.push_back(par);
              repeat (6 + 16) m_bits.push_back(1'b0);
              for (int b = 0; b < int'(i_length); b++)
                for (int j = 0; j < 8; j++) m_bits.push_back(src[b][j]);
              repeat (6) m_bits.push_back(1'b0);
              while (((m_bits.size() - 24) % nd) != 0) m_bits.push_back(1'b0);
              m_mode = 1; m_pos = 0; m_len = int'(i_length); m_nd = nd;
              m_fetched = 0; m_hold = 1'b0;
            end
          end
        end
        1: begin
          under = 1'b0;
          // Byte k is needed at frame position 39 + 8k.
          if (m_pos >= 39 && ((m_pos - 39) % 8) == 0 && ((m_pos - 39) / 8) < m_len) begin
            if (m_hold) m_hold = 1'b0;
            else under = 1'b1;
          end
          if (e_ready && i_byte_valid) begin
            m_hold = 1'b1;
            m_fetched++;
          end
          if (under) begin
            m_mode = 2; m_gap_left = GAP_CYCLES; m_err = 1'b1; m_hold = 1'b0;
          end else begin
            m_pos++;
            if (m_pos == m_bits.size()) begin
              m_mode = 2; m_gap_left = GAP_CYCLES; m_done = 1'b1;
              m_nsym = (m_bits.size() - 24) / m_nd;
            end
          end
        end
        default: begin
          m_gap_left--;
          if (m_gap_left == 0) m_mode = 0;
        end
      endcase
    end
  end

  // Run-length / SIGNAL capture / pulse counters observed on the DUT pins.
  int          run_cnt = 0;
  int          last_run = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic [23:0] sig_cap = '0;

  always @(negedge clk) begin
    if (o_sc_valid) begin
      if (run_cnt < 24) sig_cap[run_cnt] = o_sc_data;
      run_cnt++;
    end else if (run_cnt != 0) begin
      last_run = run_cnt;
      run_cnt  = 0;
    end
    if (o_done) done_cnt++;
    if (o_error) err_cnt++;
  end

  task automatic do_start(input logic [3:0] r, input logic [11:0] l);
    i_rate   = r;
    i_length = l;
    i_start  = 1'b1;
    @(posedge clk);
    #1;
    i_start  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #1;
      if (!o_busy) return;
    end
    chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sc_valid"}, o_sc_valid, 0);
    chk({tag, "_sc_data"}, o_sc_data, 0);
    chk({tag, "_byte_ready"}, o_byte_ready, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_error"}, o_error, 0);
    chk({tag, "_n_sym"}, o_n_sym, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d0;
    int          e0;
    bit          seen;
    logic [3:0]  r;
    logic [11:0] l;
    logic [3:0]  legal_rates [8];
    legal_rates = '{4'hD, 4'hF, 4'h5, 4'h7, 4'h9, 4'hB, 4'h1, 4'h3};
    for (int i = 0; i < 4096; i++) src[i] = 8'(i);

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Frame 1: rate 0xD, one byte 0xA5.
    src[0] = 8'hA5;
    d0 = done_cnt;
    do_start(4'hD, 12'd1);
    chk("t1_busy_after_start", o_busy, 1);
    chk("t1_model_len", m_bits.size(), 72);
    wait_idle(2000);
    chk("t1_valid_cycles", last_run, 72);
    chk("t1_pad", last_run - (24 + 16 + 8 + 6), 18);
    chk("t1_signal_bits", int'(sig_cap), 24'h00002B);
    chk("t1_n_sym", o_n_sym, 2);
    chk("t1_done_pulses", done_cnt - d0, 1);

    // Frame 2: rate 0x3, bytes 0..99 always available.
    for (int i = 0; i < 100; i++) src[i] = 8'(i);
    d0 = done_cnt;
    do_start(4'h3, 12'd100);
    wait_idle(3000);
    chk("t2_valid_cycles", last_run, 888);
    chk("t2_pad", last_run - (24 + 16 + 800 + 6), 42);
    chk("t2_n_sym", o_n_sym, 4);
    chk("t2_done_pulses", done_cnt - d0, 1);

    // Frame 3: same, source stalls for 20 cycles after 10 bytes.
    d0 = done_cnt;
    e0 = err_cnt;
    stall_after = 10;
    stall_len   = 20;
    do_start(4'h3, 12'd100);
    wait_idle(3000);
    stall_after = -1;
    chk("t3_valid_cycles", last_run, 24 + 16 + 80);
    chk("t3_error_pulses", err_cnt - e0, 1);
    chk("t3_done_pulses", done_cnt - d0, 0);
    do_start(4'h5, 12'd2);
    chk("t3_restart_accepted", o_busy, 1);
    wait_idle(2000);
    chk("t3_restart_valid", last_run, 24 + 48);

    // Rejected starts.
    e0 = err_cnt;
    do_start(4'h0, 12'd5);
    chk("t4_bad_rate_error", o_error, 1);
    chk("t4_bad_rate_busy", o_busy, 0);
    chk("t4_bad_rate_valid", o_sc_valid, 0);
    @(posedge clk);
    #1;
    do_start(4'hD, 12'd0);
    chk("t4_zero_len_error", o_error, 1);
    chk("t4_zero_len_busy", o_busy, 0);
    @(posedge clk);
    #1;
    chk("t4_error_pulses", err_cnt - e0, 2);

    // Starts during DATA and in the last GAP cycle are ignored.
    for (int i = 0; i < 4; i++) src[i] = 8'($urandom);
    d0 = done_cnt;
    do_start(4'hD, 12'd4);
    repeat (50) @(posedge clk);
    #1;
    do_start(4'h3, 12'd9);
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(posedge clk);
      #1;
      seen = o_done;
    end
    chk("t5_done_seen", seen, 1);
    repeat (GAP_CYCLES - 1) @(posedge clk);
    #1;
    do_start(4'h5, 12'd3);
    chk("t5_last_gap_start_ignored", o_busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_still_idle", o_busy, 0);
    chk("t5_valid_cycles", last_run, 96);
    chk("t5_n_sym", o_n_sym, 3);
    chk("t5_done_pulses", done_cnt - d0, 1);

    // Reset mid-DATA, then a fresh short frame.
    d0 = done_cnt;
    e0 = err_cnt;
    do_start(4'h3, 12'd100);
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    for (int i = 0; i < 3; i++) src[i] = 8'($urandom);
    do_start(4'h5, 12'd3);
    wait_idle(2000);
    chk("t6_n_sym", o_n_sym, 1);
    chk("t6_valid_cycles", last_run, 72);

    // Randomized frames with a bursty byte source; the model checks every cycle.
    rnd_valid = 1'b1;
    for (int it = 0; it < 14; it++) begin
      if (it % 2 == 0) r = legal_rates[$urandom_range(0, 7)];
      else r = 4'($urandom_range(0, 15));
      l = 12'($urandom_range(0, 40));
      if (it % 2 == 0 && l == 12'd0) l = 12'd1;
      for (int b = 0; b < int'(l); b++) src[b] = 8'($urandom);
      do_start(r, l);
      wait_idle(5000);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rnd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
